// File: rtl/fifo_transaccion.sv
// -----------------------------------------------------------------------------
// fifo_transaccion
//
// Transaction FIFO with occupancy-based status flags. Entries are held in a
// small register array with circular write/read pointers; a pop returns its
// entry on data_out one clock later, qualified by a one-cycle valid_out.
//
// Parameters
//   DATA_W        entry width in bits (default 10)
//   ADDR_W        pointer width; depth = 2**ADDR_W (default 3 -> 8 entries)
//
// Ports
//   clk           clock, all state changes on the rising edge
//   reset         synchronous reset, active low
//   push          write request; data_in is stored when accepted
//   data_in       write data
//   pop           read request
//   umbral_alto   almost-full threshold (from FSM interno_alto)
//   umbral_bajo   almost-empty threshold (from FSM interno_bajo)
//   data_out      registered read data, holds its value between pops
//   valid_out     data_out carries a freshly popped entry this cycle
//   fifo_empty    count == 0
//   fifo_full     count == depth
//   almost_full   count >= umbral_alto
//   almost_empty  count <= umbral_bajo
//   error         overflow/underflow indicator
//
// Build option
//   FIFO_ERROR_STICKY_EN  when defined, error latches on the first overflow or
//                         underflow and is cleared only by reset. When not
//                         defined, error is a one-cycle pulse in the cycle
//                         following each overflow or underflow.
// -----------------------------------------------------------------------------
module fifo_transaccion #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   input  logic [2:0]        umbral_alto,
   input  logic [2:0]        umbral_bajo,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              error
);

   localparam int                 DEPTH     = 2 ** ADDR_W;
   localparam int                 CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [DATA_W-1:0] mem_reg [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_reg,   wr_ptr_next;
   logic [ADDR_W-1:0] rd_ptr_reg,   rd_ptr_next;
   logic [CNT_W-1:0]  count_reg,    count_next;
   logic [DATA_W-1:0] data_out_reg, data_out_next;
   logic              valid_reg,    valid_next;
   logic              error_reg,    error_next;

   // -------------------------------------------------------------------------
   // Request qualification
   // -------------------------------------------------------------------------
   logic push_ok;
   logic pop_ok;
   logic overflow;
   logic underflow;

   // Thresholds are 3-bit inputs; widen them to the count width so the
   // comparison is unsigned and never truncates the count.
   logic [CNT_W-1:0] alto_ext;
   logic [CNT_W-1:0] bajo_ext;

   assign alto_ext = CNT_W'(umbral_alto);
   assign bajo_ext = CNT_W'(umbral_bajo);

   assign fifo_empty   = (count_reg == '0);
   assign fifo_full    = (count_reg == DEPTH_CNT);
   assign almost_full  = (count_reg >= alto_ext);
   assign almost_empty = (count_reg <= bajo_ext);

   // A pop on a full FIFO frees a slot in the same cycle, so a simultaneous
   // push is still accepted. A pop on an empty FIFO has nothing to return,
   // so a simultaneous push goes through alone.
   assign pop_ok    = pop && !fifo_empty;
   assign push_ok   = push && (!fifo_full || pop);
   assign overflow  = push && fifo_full && !pop;
   assign underflow = pop && fifo_empty;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      data_out_next = data_out_reg;
      valid_next    = 1'b0;

      if (push_ok) begin
         // Depth is a power of two, so the pointer wraps naturally.
         wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
      end

      if (pop_ok) begin
         rd_ptr_next   = rd_ptr_reg + ADDR_W'(1);
         data_out_next = mem_reg[rd_ptr_reg];
         valid_next    = 1'b1;
      end

      unique case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

`ifdef FIFO_ERROR_STICKY_EN
   assign error_next = error_reg | overflow | underflow;
`else
   assign error_next = overflow | underflow;
`endif

   // -------------------------------------------------------------------------
   // Storage: no reset on the array, only pointers and count define validity.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= data_in;
      end
   end

   // -------------------------------------------------------------------------
   // Control registers; reset wins over any push/pop in the same cycle.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         data_out_reg <= '0;
         valid_reg    <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         data_out_reg <= data_out_next;
         valid_reg    <= valid_next;
         error_reg    <= error_next;
      end
   end

   assign data_out  = data_out_reg;
   assign valid_out = valid_reg;
   assign error     = error_reg;

endmodule
